// File: rtl/booth_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
package booth_pkg;

  // FSM state encodings
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // One-hot partial-product select; all-zero means a zero digit
  typedef struct packed {
    logic neg;
    logic pos;
    logic neg2;
    logic pos2;
  } booth_sel_t;

  localparam booth_sel_t SelZero = 4'b0000;
  localparam booth_sel_t SelNeg  = 4'b1000;
  localparam booth_sel_t SelPos  = 4'b0100;
  localparam booth_sel_t SelNeg2 = 4'b0010;
  localparam booth_sel_t SelPos2 = 4'b0001;

  // Number of Booth digits for an operand extended by two bits
  function automatic int unsigned calc_nd(input int unsigned width);
    return (width + 2) / 2;
  endfunction

  // Accumulation cycles needed to retire all digits
  function automatic int unsigned calc_iter(input int unsigned width, input int unsigned dpc);
    return (calc_nd(width) + dpc - 1) / dpc;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth digit decoder and partial-product generator.
// The negate carry is returned separately so the caller adds it at the digit LSB.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int unsigned EW = 10
) (
  input  logic [2:0]    digit_i,
  input  logic [EW-1:0] x_i,
  output booth_sel_t    sel_o,
  output logic [EW:0]   pp_o,
  output logic          neg_o
);

  // Decode the 3-bit Booth digit into a one-hot select
  always_comb begin
    unique case (digit_i)
      3'b001, 3'b010: sel_o = SelPos;
      3'b011:         sel_o = SelPos2;
      3'b100:         sel_o = SelNeg2;
      3'b101, 3'b110: sel_o = SelNeg;
      default:        sel_o = SelZero;
    endcase
  end

  // Form +-X / +-2X at EW+1 bits; negative terms are one's complement here
  always_comb begin
    pp_o = '0;
    if (sel_o.pos) begin
      pp_o = {x_i[EW-1], x_i};
    end else if (sel_o.pos2) begin
      pp_o = {x_i, 1'b0};
    end else if (sel_o.neg) begin
      pp_o = ~{x_i[EW-1], x_i};
    end else if (sel_o.neg2) begin
      pp_o = ~{x_i, 1'b0};
    end
  end

  assign neg_o = sel_o.neg | sel_o.neg2;

endmodule

// File: rtl/booth_radix4_iter_mul.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides.
// Retires DIGITS_PER_CYCLE Booth digits per clock into a 2*WIDTH+2 bit accumulator.
module booth_radix4_iter_mul
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned DIGITS_PER_CYCLE = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_signed_i,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] out_p_o
);

  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned ND   = calc_nd(WIDTH);
  localparam int unsigned ITER = calc_iter(WIDTH, DIGITS_PER_CYCLE);
  localparam int unsigned AW   = 2 * WIDTH + 2;
  localparam int unsigned YW   = EW + 1;
  localparam int unsigned CW   = $clog2(ITER);
  // With two digits per cycle and an odd digit count the final slot has no real digit
  localparam bit OddTail = (DIGITS_PER_CYCLE == 2) && ((ND % 2) == 1);
  localparam logic [CW-1:0] LastCnt = CW'(ITER - 1);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_radix4_iter_mul: WIDTH must be even and >= 4");
  end
  if ((DIGITS_PER_CYCLE != 1) && (DIGITS_PER_CYCLE != 2)) begin : g_bad_dpc
    $error("booth_radix4_iter_mul: DIGITS_PER_CYCLE must be 1 or 2");
  end

  logic [1:0]         state_q, state_d;
  logic [EW-1:0]      x_q, x_d;
  // Multiplier with the implicit Y[-1]=0 appended; shifted right as digits retire
  logic [YW-1:0]      ys_q, ys_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d, sum;
  logic [2*WIDTH-1:0] out_p_q, out_p_d;
  logic               out_valid_q, out_valid_d;
  logic               last_cycle;
  logic               sign_a, sign_b;

  booth_sel_t         sel [DIGITS_PER_CYCLE];
  logic [EW:0]        pp  [DIGITS_PER_CYCLE];
  logic               neg [DIGITS_PER_CYCLE];

  assign last_cycle = (cnt_q == LastCnt);
  assign sign_a     = in_signed_i & in_a_i[WIDTH-1];
  assign sign_b     = in_signed_i & in_b_i[WIDTH-1];

  for (genvar k = 0; k < DIGITS_PER_CYCLE; k++) begin : g_pp
    logic [2:0] digit;
    if (OddTail && (k == DIGITS_PER_CYCLE - 1)) begin : g_tail
      assign digit = last_cycle ? 3'b000 : ys_q[2*k+2:2*k];
    end else begin : g_plain
      assign digit = ys_q[2*k+2:2*k];
    end

    booth_pp_gen #(
      .EW (EW)
    ) u_pp_gen (
      .digit_i (digit),
      .x_i     (x_q),
      .sel_o   (sel[k]),
      .pp_o    (pp[k]),
      .neg_o   (neg[k])
    );
  end

  // Add this cycle's partial products, each weighted by 4^j for its digit index j
  always_comb begin
    logic [AW-1:0] term;
    int unsigned   sh;
    sum  = acc_q;
    term = '0;
    sh   = 0;
    for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
      sh = 2 * (32'(cnt_q) * DIGITS_PER_CYCLE + 32'(k));
      if (|sel[k]) begin
        term = {{(AW-EW-1){pp[k][EW]}}, pp[k]} + AW'(neg[k]);
        sum  = sum + (term << sh);
      end
    end
  end

  // FSM, operand capture, accumulation and output handshake
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    ys_d        = ys_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      state_d     = StIdle;
      cnt_d       = '0;
      acc_d       = '0;
      out_p_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            x_d     = {{2{sign_a}}, in_a_i};
            ys_d    = {{2{sign_b}}, in_b_i, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
        StBusy: begin
          acc_d = sum;
          ys_d  = ys_q >> (2 * DIGITS_PER_CYCLE);
          cnt_d = cnt_q + CW'(1);
          if (last_cycle) begin
            out_p_d     = sum[2*WIDTH-1:0];
            out_valid_d = 1'b1;
            state_d     = StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      x_q         <= '0;
      ys_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      ys_q        <= ys_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign out_p_o     = out_p_q;

endmodule

// File: tb/tb_booth_radix4_iter_mul.sv
// Directed and randomised checks of booth_radix4_iter_mul at three configurations.
module tb_booth_radix4_iter_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  // WIDTH=8, DIGITS_PER_CYCLE=1 (ITER=5)
  logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        in_ready, out_valid;
  logic [15:0] out_p;

  // Shared operands for the wide configurations
  logic [31:0] ra = '0, rb = '0;
  logic        rs = 1'b0;

  // WIDTH=16, DIGITS_PER_CYCLE=2 (ITER=5, odd digit count)
  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic        in_ready2, out_valid2;
  logic [31:0] out_p2;

  // WIDTH=32, DIGITS_PER_CYCLE=1 (ITER=17)
  logic        in_valid3 = 1'b0, out_ready3 = 1'b0;
  logic        in_ready3, out_valid3;
  logic [63:0] out_p3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_radix4_iter_mul #(.WIDTH(8), .DIGITS_PER_CYCLE(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_signed_i(in_signed), .in_a_i(in_a), .in_b_i(in_b), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_p_o(out_p)
  );

  booth_radix4_iter_mul #(.WIDTH(16), .DIGITS_PER_CYCLE(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .in_signed_i(rs), .in_a_i(ra[15:0]), .in_b_i(rb[15:0]), .out_valid_o(out_valid2),
    .out_ready_i(out_ready2), .out_p_o(out_p2)
  );

  booth_radix4_iter_mul #(.WIDTH(32), .DIGITS_PER_CYCLE(1)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
    .in_signed_i(rs), .in_a_i(ra), .in_b_i(rb), .out_valid_o(out_valid3),
    .out_ready_i(out_ready3), .out_p_o(out_p3)
  );

  // Issue one op on the 8-bit DUT from IDLE, return product and accept-to-valid latency
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] p, output int lat);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    p = out_p;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b p=%h want valid=0 p=0000", out_valid, out_p);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_products();
    logic [7:0]  ta [9];
    logic [7:0]  tb [9];
    logic        ts [9];
    logic [15:0] te [9];
    logic [15:0] p;
    int          lat;
    ta = '{8'h80, 8'hFF, 8'h80, 8'hFF, 8'h80, 8'h7F, 8'h05, 8'h00, 8'h12};
    tb = '{8'h80, 8'hFF, 8'h7F, 8'hFF, 8'h02, 8'h7F, 8'hFD, 8'hAB, 8'h34};
    ts = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    te = '{16'h4000, 16'hFE01, 16'hC080, 16'h0001, 16'h0100, 16'h3F01, 16'hFFF1, 16'h0000,
           16'h03A8};
    for (int i = 0; i < 9; i++) begin
      run_op(ta[i], tb[i], ts[i], p, lat);
      checks++;
      if (p !== te[i]) begin
        failures++;
        $display("FAIL product[%0d] %h*%h s=%b: got %h want %h", i, ta[i], tb[i], ts[i], p, te[i]);
      end
      checks++;
      if (lat != 5) begin
        failures++;
        $display("FAIL latency[%0d]: got %0d want 5", i, lat);
      end
    end
  endtask

  task automatic test_stall_done();
    int lat;
    in_a = 8'h12; in_b = 8'h34; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
    checks++;
    if (lat != 5 || out_p !== 16'h03A8) begin
      failures++;
      $display("FAIL stall_first: got lat=%0d p=%h want lat=5 p=03a8", lat, out_p);
    end
    // New request presented while the result waits; it must be ignored
    in_a = 8'h0B; in_b = 8'h0D; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_p} !== {1'b1, 1'b0, 16'h03A8}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got valid=%b ready=%b p=%h want valid=1 ready=0 p=03a8",
                 c, out_valid, in_ready, out_p);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    // in_valid still high: accepted on this edge
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_reaccept: got ready=%b want 0", in_ready);
    end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
    checks++;
    if (lat != 5 || out_p !== 16'h008F) begin
      failures++;
      $display("FAIL stall_next: got lat=%0d p=%h want lat=5 p=008f", lat, out_p);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic        seen;
    logic [15:0] p;
    int          lat;
    in_a = 8'h09; in_b = 8'h09; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 16'h0000) begin
      failures++;
      $display("FAIL flush_busy: got ready=%b valid=%b p=%h want ready=1 valid=0 p=0000",
               in_ready, out_valid, out_p);
    end
    // Flush together with an accept: op dropped
    in_a = 8'h03; in_b = 8'h05; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_accept: got ready=%b want 1", in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_valid: got seen=%b want 0", seen);
    end
    run_op(8'h03, 8'h05, 1'b0, p, lat);
    checks++;
    if (p !== 16'h000F || lat != 5) begin
      failures++;
      $display("FAIL flush_next: got p=%h lat=%0d want p=000f lat=5", p, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] p;
    int          lat;
    in_a = 8'h7F; in_b = 8'h7F; in_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== 16'h0000) begin
      failures++;
      $display("FAIL rst_busy: got valid=%b p=%h want valid=0 p=0000", out_valid, out_p);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy_release: got ready=%b valid=%b want ready=1 valid=0",
               in_ready, out_valid);
    end
    // Reset while a result is presented clears it without waiting for an edge
    in_a = 8'h05; in_b = 8'hFD; in_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    checks++;
    if (out_valid !== 1'b1 || out_p !== 16'hFFF1) begin
      failures++;
      $display("FAIL rst_pre_done: got valid=%b p=%h want valid=1 p=fff1", out_valid, out_p);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== 16'h0000) begin
      failures++;
      $display("FAIL rst_done: got valid=%b p=%h want valid=0 p=0000", out_valid, out_p);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'h7F, 8'h7F, 1'b1, p, lat);
    checks++;
    if (p !== 16'h3F01 || lat != 5) begin
      failures++;
      $display("FAIL rst_next: got p=%h lat=%0d want p=3f01 lat=5", p, lat);
    end
  endtask

  // Random ops with stalls on both sides against a '*' reference; which=2 or 3
  task automatic test_random(input int which, input int n_ops);
    logic [31:0] a, b;
    logic        s, ov;
    logic [63:0] ea, eb, expp, got;
    int          lat, exp_lat, d;
    exp_lat = (which == 2) ? 5 : 17;
    for (int op = 0; op < n_ops; op++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (op % 10 == 0) begin
        a = 32'h8000_8000;
        b = 32'h8000_8000;
      end
      if (which == 2) begin
        ea = s ? {{48{a[15]}}, a[15:0]} : {48'b0, a[15:0]};
        eb = s ? {{48{b[15]}}, b[15:0]} : {48'b0, b[15:0]};
        expp = (ea * eb) & 64'h0000_0000_FFFF_FFFF;
      end else begin
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        expp = ea * eb;
      end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        @(posedge clk); #1;
      end
      ra = a; rb = b; rs = s;
      if (which == 2) in_valid2 = 1'b1;
      else in_valid3 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0; in_valid3 = 1'b0;
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
        @(posedge clk); #1;
        ov = (which == 2) ? out_valid2 : out_valid3;
        if (ov) begin lat = c; break; end
      end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        @(posedge clk); #1;
      end
      got = (which == 2) ? {32'b0, out_p2} : out_p3;
      checks++;
      if (got !== expp) begin
        failures++;
        $display("FAIL random%0d[%0d] %h*%h s=%b: got %h want %h", which, op, a, b, s, got, expp);
      end
      checks++;
      if (lat != exp_lat) begin
        failures++;
        $display("FAIL random%0d_latency[%0d]: got %0d want %0d", which, op, lat, exp_lat);
      end
      if (which == 2) out_ready2 = 1'b1;
      else out_ready3 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0; out_ready3 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_stall_done();
    test_flush();
    test_async_reset();
    test_random(2, 300);
    test_random(3, 150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
